// File: rtl/ddr_arbiter_if.sv
// Avalon-MM style burst port between a DDR client and the arbiter.
// master drives commands and write data; slave answers with stall, read valid and read data.
interface ddr_arbiter_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_WIDTH = 8
);
  logic                    rd;
  logic                    wr;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [BURST_WIDTH-1:0]  burstCount;
  logic [DATA_WIDTH/8-1:0] mask;
  logic [DATA_WIDTH-1:0]   din;
  logic                    waitReq;
  logic                    valid;
  logic [DATA_WIDTH-1:0]   dout;

  modport master (output rd, wr, addr, burstCount, mask, din,
                  input  waitReq, valid, dout);
  modport slave  (input  rd, wr, addr, burstCount, mask, din,
                  output waitReq, valid, dout);
endinterface

// File: rtl/ddr_arbiter.sv
// Two-client burst arbiter for the DDRAM port: round-robin grant held for a whole
// burst, commands forwarded with no added latency, read valids steered to the owner.
module ddr_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  ddr_arbiter_if.slave  in0,
  ddr_arbiter_if.slave  in1,
  ddr_arbiter_if.master out,
  output logic          busy
);
  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                 state;
  logic                   owner;
  logic                   last;
  logic [BURST_WIDTH-1:0] remaining;

  logic [1:0]                  rd_v, wr_v, req;
  logic [1:0][ADDR_WIDTH-1:0]  addr_v;
  logic [1:0][BURST_WIDTH-1:0] burst_v;
  logic [1:0][MW-1:0]          mask_v;
  logic [1:0][DATA_WIDTH-1:0]  din_v;

  assign rd_v    = {in1.rd, in0.rd};
  assign wr_v    = {in1.wr, in0.wr};
  assign addr_v  = {in1.addr, in0.addr};
  assign burst_v = {in1.burstCount, in0.burstCount};
  assign mask_v  = {in1.mask, in0.mask};
  assign din_v   = {in1.din, in0.din};
  assign req     = rd_v | wr_v;

  // Round-robin only matters under contention; a lone requester always wins.
  logic win, sel;
  assign win = (req == 2'b11) ? ~last : req[1];
  assign sel = (state == IDLE) ? win : owner;

  logic [BURST_WIDTH-1:0] burst_eff;
  assign burst_eff = (burst_v[sel] == '0) ? BURST_WIDTH'(1) : burst_v[sel];

  logic       issue_rd, issue_wr, accept;
  logic [1:0] wait_v, valid_v;

  always_comb begin
    issue_rd = 1'b0;
    issue_wr = 1'b0;
    wait_v   = 2'b00;
    valid_v  = 2'b00;
    if (rst) begin
      wait_v = 2'b11;
    end else begin
      case (state)
        IDLE: if (|req) begin
          // A requester raising rd and wr together gets the read only.
          issue_rd     = rd_v[win];
          issue_wr     = wr_v[win] & ~rd_v[win];
          wait_v       = 2'b11;
          wait_v[win]  = out.waitReq;
        end
        READ: begin
          wait_v         = 2'b11;
          valid_v[owner] = out.valid;
        end
        WRITE: begin
          issue_wr      = wr_v[owner];
          wait_v        = 2'b11;
          wait_v[owner] = out.waitReq;
        end
        default: ;
      endcase
    end
  end

  assign accept = (issue_rd | issue_wr) & ~out.waitReq;

  assign out.rd         = issue_rd;
  assign out.wr         = issue_wr;
  assign out.addr       = addr_v[sel];
  assign out.burstCount = burst_v[sel];
  assign out.mask       = mask_v[sel];
  assign out.din        = din_v[sel];

  assign in0.waitReq = wait_v[0];
  assign in1.waitReq = wait_v[1];
  assign in0.valid   = valid_v[0];
  assign in1.valid   = valid_v[1];
  assign in0.dout    = out.dout;
  assign in1.dout    = out.dout;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      remaining <= '0;
      last      <= 1'b1;
    end else begin
      case (state)
        IDLE: if (accept) begin
          owner <= win;
          last  <= win;
          if (issue_rd) begin
            state     <= READ;
            remaining <= burst_eff;
          end else if (burst_eff != BURST_WIDTH'(1)) begin
            // First beat already went out with the command.
            state     <= WRITE;
            remaining <= burst_eff - BURST_WIDTH'(1);
          end
        end
        READ: if (out.valid) begin
          remaining <= remaining - BURST_WIDTH'(1);
          if (remaining == BURST_WIDTH'(1)) state <= IDLE;
        end
        WRITE: if (accept) begin
          remaining <= remaining - BURST_WIDTH'(1);
          if (remaining == BURST_WIDTH'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_arbiter.sv
// Random two-client traffic against a DDR responder; a monitor keeps a
// transaction-level model and scoreboards commands, write beats and read data.
module tb_ddr_arbiter;
  localparam int AW = 32, DW = 64, BW = 8, MW = DW / 8;

  typedef struct {
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] bc;
    int            gap;
  } txn_t;

  typedef struct {
    logic [DW-1:0] din;
    logic [MW-1:0] mask;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  always #5 clk = ~clk;

  ddr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) in0 ();
  ddr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) in1 ();
  ddr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) out ();

  ddr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .in0(in0), .in1(in1), .out(out), .busy(busy)
  );

  int checks = 0, errors = 0;
  bit fin = 1'b0, main_tmo = 1'b0, hold_wait = 1'b0;
  int mon_v0 = 0, mon_ph = 0;
  logic [DW-1:0] ddr_q[$];

  function automatic int eff(logic [BW-1:0] bc);
    return (bc == '0) ? 1 : int'(bc);
  endfunction

  // Read data is a pure function of the read's sequence number and beat index.
  function automatic logic [DW-1:0] rdata(int seq, int k);
    logic [31:0] h;
    h = 32'(seq) * 32'h9E37_79B9;
    return {h, 8'(k), 24'hC0FFEE};
  endfunction

  // ---------------- requesters ----------------
  for (genvar g = 0; g < 2; g++) begin : rq
    logic          rd = 1'b0, wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [BW-1:0] bc = '0;
    logic [MW-1:0] mask = '0;
    logic [DW-1:0] din = '0;
    logic          wreq;
    txn_t  todo[$];
    txn_t  cmd_q[$];
    beat_t wq[$];
    bit    act = 1'b0, tmo = 1'b0;

    assign wreq = (g == 0) ? in0.waitReq : in1.waitReq;

    initial begin
      txn_t  t;
      beat_t bt[$];
      beat_t x;
      int    n, cyc;
      @(posedge clk); #1;
      forever begin
        if (todo.size() == 0) begin
          act = 1'b0; rd = 1'b0; wr = 1'b0;
          @(posedge clk); #1;
        end else begin
          act = 1'b1;
          t = todo.pop_front();
          rd = 1'b0; wr = 1'b0;
          repeat (t.gap) begin @(posedge clk); #1; end
          n = t.rd ? 1 : eff(t.bc);
          bt.delete();
          for (int b = 0; b < n; b++) begin
            x.din  = {$urandom, $urandom};
            x.mask = MW'($urandom);
            bt.push_back(x);
            if (!t.rd) wq.push_back(x);
          end
          cmd_q.push_back(t);
          rd = t.rd; wr = t.wr; addr = t.addr; bc = t.bc;
          for (int b = 0; b < n; b++) begin
            din = bt[b].din; mask = bt[b].mask; cyc = 0;
            forever begin
              @(negedge clk);
              if (!wreq) break;
              cyc++;
              if (cyc > 500) begin tmo = 1'b1; break; end
              @(posedge clk); #1;
            end
            @(posedge clk); #1;
          end
        end
      end
    end
  end

  assign in0.rd = rq[0].rd;     assign in1.rd = rq[1].rd;
  assign in0.wr = rq[0].wr;     assign in1.wr = rq[1].wr;
  assign in0.addr = rq[0].addr; assign in1.addr = rq[1].addr;
  assign in0.burstCount = rq[0].bc;  assign in1.burstCount = rq[1].bc;
  assign in0.mask = rq[0].mask; assign in1.mask = rq[1].mask;
  assign in0.din = rq[0].din;   assign in1.din = rq[1].din;

  // ---------------- DDR responder ----------------
  initial begin
    int seq = 0;
    out.waitReq = 1'b0; out.valid = 1'b0; out.dout = '0;
    forever begin
      @(posedge clk); #1;
      out.waitReq = hold_wait || ($urandom_range(0, 3) == 0);
      if (ddr_q.size() != 0 && $urandom_range(0, 2) != 0) begin
        out.valid = 1'b1; out.dout = ddr_q.pop_front();
      end else if (ddr_q.size() == 0 && $urandom_range(0, 15) == 0) begin
        out.valid = 1'b1; out.dout = {$urandom, $urandom};
      end else begin
        out.valid = 1'b0; out.dout = {$urandom, $urandom};
      end
      @(negedge clk);
      if (!rst && out.rd && !out.waitReq) begin
        for (int k = 0; k < eff(out.burstCount); k++) ddr_q.push_back(rdata(seq, k));
        seq++;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void pop_cmd(bit w, output txn_t c);
    chk("cmdq_nonempty", 64'(w ? rq[1].cmd_q.size() != 0 : rq[0].cmd_q.size() != 0), 64'd1);
    c = '{0, 0, '0, '0, 0};
    if (w && rq[1].cmd_q.size() != 0) c = rq[1].cmd_q.pop_front();
    else if (!w && rq[0].cmd_q.size() != 0) c = rq[0].cmd_q.pop_front();
  endfunction

  function automatic void check_beat(bit w);
    beat_t b;
    chk("wq_nonempty", 64'(w ? rq[1].wq.size() != 0 : rq[0].wq.size() != 0), 64'd1);
    if (w ? rq[1].wq.size() == 0 : rq[0].wq.size() == 0) return;
    b = w ? rq[1].wq.pop_front() : rq[0].wq.pop_front();
    chk("wr_din", out.din, b.din);
    chk("wr_mask", 64'(out.mask), 64'(b.mask));
  endfunction

  initial begin
    logic [DW-1:0] rsp_exp[2][$];
    int   ph = 0, rem = 0, seq = 0;
    bit   own = 1'b0, lst = 1'b1, w = 1'b0, r0, r1, erd, ewr, ebusy;
    bit [1:0] ew, ev;
    txn_t c;
    forever begin
      @(negedge clk);
      if (fin) begin
        chk("end_rsp0", 64'(rsp_exp[0].size()), 64'd0);
        chk("end_rsp1", 64'(rsp_exp[1].size()), 64'd0);
        chk("end_cmdq0", 64'(rq[0].cmd_q.size()), 64'd0);
        chk("end_cmdq1", 64'(rq[1].cmd_q.size()), 64'd0);
        chk("end_wq0", 64'(rq[0].wq.size()), 64'd0);
        chk("end_wq1", 64'(rq[1].wq.size()), 64'd0);
        chk("req0_timeout", 64'(rq[0].tmo), 64'd0);
        chk("req1_timeout", 64'(rq[1].tmo), 64'd0);
        chk("main_timeout", 64'(main_tmo), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (rst) begin
        ph = 0; own = 1'b0; lst = 1'b1; rem = 0; mon_ph = 0;
        rsp_exp[0].delete(); rsp_exp[1].delete();
        chk("rst_out_rd", 64'(out.rd), 64'd0);
        chk("rst_out_wr", 64'(out.wr), 64'd0);
        chk("rst_valid0", 64'(in0.valid), 64'd0);
        chk("rst_valid1", 64'(in1.valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        continue;
      end
      r0 = in0.rd | in0.wr;
      r1 = in1.rd | in1.wr;
      erd = 1'b0; ewr = 1'b0; ew = 2'b00; ev = 2'b00; ebusy = (ph != 0);
      case (ph)
        0: begin
          w = (r0 && r1) ? ~lst : r1;
          if (r0 || r1) begin
            erd = w ? in1.rd : in0.rd;
            ewr = !erd && (w ? in1.wr : in0.wr);
            ew = 2'b11; ew[w] = out.waitReq;
          end
        end
        1: begin ew = 2'b11; ev[own] = out.valid; end
        default: begin
          ewr = own ? in1.wr : in0.wr;
          ew = 2'b11; ew[own] = out.waitReq;
        end
      endcase
      chk("out_rd", 64'(out.rd), 64'(erd));
      chk("out_wr", 64'(out.wr), 64'(ewr));
      chk("waitReq0", 64'(in0.waitReq), 64'(ew[0]));
      chk("waitReq1", 64'(in1.waitReq), 64'(ew[1]));
      chk("valid0", 64'(in0.valid), 64'(ev[0]));
      chk("valid1", 64'(in1.valid), 64'(ev[1]));
      chk("busy", 64'(busy), 64'(ebusy));
      chk("dout0", in0.dout, out.dout);
      chk("dout1", in1.dout, out.dout);

      if (ph == 0 && (erd || ewr) && !out.waitReq) begin
        pop_cmd(w, c);
        chk("cmd_addr", 64'(out.addr), 64'(c.addr));
        chk("cmd_burst", 64'(out.burstCount), 64'(c.bc));
        own = w; lst = w;
        if (erd) begin
          ph = 1; rem = eff(c.bc);
          for (int k = 0; k < rem; k++) rsp_exp[w].push_back(rdata(seq, k));
          seq++;
        end else begin
          check_beat(w);
          if (eff(c.bc) > 1) begin ph = 2; rem = eff(c.bc) - 1; end
        end
      end else if (ph == 1 && out.valid) begin
        chk("rsp_nonempty", 64'(rsp_exp[own].size() != 0), 64'd1);
        if (rsp_exp[own].size() != 0)
          chk("rd_data", own ? in1.dout : in0.dout, rsp_exp[own].pop_front());
        if (!own) mon_v0++;
        rem--;
        if (rem == 0) ph = 0;
      end else if (ph == 2 && ewr && !out.waitReq) begin
        check_beat(own);
        rem--;
        if (rem == 0) ph = 0;
      end
      mon_ph = ph;
    end
  end

  // ---------------- sequencing ----------------
  task automatic wait_idle();
    int cyc = 0;
    forever begin
      @(negedge clk);
      if (rq[0].todo.size() == 0 && rq[1].todo.size() == 0 && !rq[0].act && !rq[1].act &&
          mon_ph == 0 && ddr_q.size() == 0) break;
      cyc++;
      if (cyc > 30000) begin main_tmo = 1'b1; break; end
    end
  endtask

  initial begin
    txn_t t;
    int   v;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Contention opener, then randomized traffic from both clients.
    @(negedge clk);
    t = '{1'b1, 1'b0, 32'h1000, 8'd4, 0}; rq[0].todo.push_back(t);
    t = '{1'b0, 1'b1, 32'h2000, 8'd1, 0}; rq[1].todo.push_back(t);
    for (int i = 0; i < 40; i++) begin
      for (int g = 0; g < 2; g++) begin
        t.rd   = ($urandom_range(0, 1) == 1);
        t.wr   = t.rd ? ($urandom_range(0, 5) == 0) : 1'b1;
        t.addr = $urandom;
        t.bc   = BW'($urandom_range(0, 4));
        t.gap  = $urandom_range(0, 2);
        if (g == 0) rq[0].todo.push_back(t); else rq[1].todo.push_back(t);
      end
    end
    wait_idle();

    // Held stall at the DDR while both clients request.
    @(negedge clk);
    hold_wait = 1'b1;
    t = '{1'b1, 1'b0, 32'h3000, 8'd2, 0}; rq[0].todo.push_back(t);
    t = '{1'b0, 1'b1, 32'h4000, 8'd1, 0}; rq[1].todo.push_back(t);
    repeat (6) @(negedge clk);
    hold_wait = 1'b0;
    wait_idle();

    // Reset in the middle of a 4-beat read, two beats still outstanding.
    @(negedge clk);
    v = mon_v0;
    t = '{1'b1, 1'b0, 32'h1000, 8'd4, 0}; rq[0].todo.push_back(t);
    begin
      int cyc = 0;
      forever begin
        @(posedge clk);
        if (mon_v0 >= v + 2) break;
        cyc++;
        if (cyc > 500) begin main_tmo = 1'b1; break; end
      end
    end
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_idle();

    // After reset: lone in1 request, then contention where in0 must win first.
    @(negedge clk);
    t = '{1'b0, 1'b1, 32'h5000, 8'd2, 0}; rq[1].todo.push_back(t);
    wait_idle();
    @(negedge clk);
    t = '{1'b1, 1'b1, 32'h6000, 8'd0, 0}; rq[0].todo.push_back(t);
    t = '{1'b0, 1'b1, 32'h7000, 8'd3, 0}; rq[1].todo.push_back(t);
    wait_idle();
    fin = 1'b1;
  end
endmodule
